// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for a five-stage MIPS pipeline. It sits beside the ID
// stage and keeps a shadow copy of the destination, regWrite and memRead
// state of the instructions in EX, MEM and WB. From that copy it detects
// read-after-write hazards against the instruction now in ID. On a hazard it
// holds the PC and IF/ID registers and injects a bubble into ID/EX.
//
// Build option:
//   HAZARD_FORWARD_EN  defined   : stall only on load-use. Registered ALU
//                                  operand forward selects are produced.
//                      undefined : stall on any RAW against EX or MEM.
//                                  Forward selects are tied to 00.
//
// Ports:
//   clk_i            pipeline clock; state updates on the rising edge
//   rst_i            asynchronous, active-high reset
//   id_valid_i       ID holds a real instruction
//   id_rs_i          rs field of the ID instruction
//   id_rt_i          rt field of the ID instruction
//   id_uses_rt_i     ID instruction reads rt (R-type, beq, sw)
//   id_dest_i        destination register, already muxed by regDst
//   id_reg_write_i   ID instruction writes the register file
//   id_mem_read_i    ID instruction is a load
//   flush_i          taken branch/jump kills the ID instruction this cycle
//   stall_o          hazard detected (combinational)
//   pc_write_o       !stall_o
//   ifid_write_o     !stall_o
//   ex_bubble_o      stall_o | flush_o; zeroes ID/EX control fields
//   fwd_a_o          operand-A select for the EX instruction (registered):
//                    00 = register file, 01 = EX/MEM, 10 = MEM/WB
//   fwd_b_o          same as fwd_a_o, for operand B
//   stall_count_o    saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic [4:0]       id_dest_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ex_bubble_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_count_o
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;

    // An entry produces register r if it will really write it; $zero never
    // counts because writes to it are discarded.
    function automatic logic writes_reg(input shadow_t e, input logic [4:0] r);
        return e.valid && e.reg_write && (e.dest != 5'd0) && (e.dest == r);
    endfunction

    function automatic logic matches_id(input shadow_t    e,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt,
                                        input logic       uses_rt);
        return writes_reg(e, rs) || (uses_rt && writes_reg(e, rt));
    endfunction

    shadow_t s_ex_q, s_mem_q, s_wb_q;
    shadow_t s_ex_d;

    logic             ex_match;
    logic             hazard;
    logic             stall_c;
    logic             ex_bubble_c;
    logic             enter_ex;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // -------------------------------------------------------------------------
    // Hazard detection. The register file writes on the rising edge and reads
    // on the falling edge, so the WB entry is never a hazard source.
    // -------------------------------------------------------------------------
    always_comb begin
        ex_match = matches_id(s_ex_q, id_rs_i, id_rt_i, id_uses_rt_i);
`ifdef HAZARD_FORWARD_EN
        // Everything but a load in EX can be forwarded in time.
        hazard = s_ex_q.mem_read && ex_match;
`else
        hazard = ex_match || matches_id(s_mem_q, id_rs_i, id_rt_i, id_uses_rt_i);
`endif
    end

    // Outputs are gated by reset so a stall in progress is dropped at once,
    // without waiting for the shadow registers to clear.
    always_comb begin
        stall_c     = !rst_i && id_valid_i && !flush_i && hazard;
        ex_bubble_c = !rst_i && (stall_c || flush_i);
        enter_ex    = id_valid_i && !ex_bubble_c;
    end

    assign stall_o       = stall_c;
    assign pc_write_o    = !stall_c;
    assign ifid_write_o  = !stall_c;
    assign ex_bubble_o   = ex_bubble_c;
    assign stall_count_o = stall_cnt_q;

    // -------------------------------------------------------------------------
    // Shadow pipeline
    // -------------------------------------------------------------------------
    always_comb begin
        s_ex_d = '0;
        if (enter_ex) begin
            s_ex_d.valid     = 1'b1;
            s_ex_d.dest      = id_dest_i;
            s_ex_d.reg_write = id_reg_write_i;
            s_ex_d.mem_read  = id_mem_read_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_ex_q  <= '0;
            s_mem_q <= '0;
            s_wb_q  <= '0;
        end else begin
            s_ex_q  <= s_ex_d;
            s_mem_q <= s_ex_q;
            s_wb_q  <= s_mem_q;
        end
    end

    // The WB entry and some memRead bits are kept for a complete record of
    // the pipeline but are not consulted by the hazard equations.
    logic unused_shadow;
    assign unused_shadow = ^{s_wb_q, s_ex_q.mem_read, s_mem_q.mem_read};

    // -------------------------------------------------------------------------
    // Stall counter, saturating at all ones
    // -------------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand forward selects
    // -------------------------------------------------------------------------
`ifdef HAZARD_FORWARD_EN
    // The nearer producer wins: EX result (01) over MEM result (10).
    function automatic logic [1:0] fwd_sel(input shadow_t    ex_e,
                                           input shadow_t    mem_e,
                                           input logic [4:0] r);
        if (writes_reg(ex_e, r)) begin
            return 2'b01;
        end else if (writes_reg(mem_e, r)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (enter_ex) begin
            fwd_a_d = fwd_sel(s_ex_q, s_mem_q, id_rs_i);
            if (id_uses_rt_i) begin
                fwd_b_d = fwd_sel(s_ex_q, s_mem_q, id_rt_i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_o = fwd_a_q;
    assign fwd_b_o = fwd_b_q;
`else
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic       stall;
    logic       pc_write;
    logic       ifid_write;
    logic       ex_bubble;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic [3:0] stall_count;

    hazard_ctrl #(.CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_valid_i     (id_valid),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rt_i   (id_uses_rt),
        .id_dest_i      (id_dest),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .flush_i        (flush),
        .stall_o        (stall),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ex_bubble_o    (ex_bubble),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b),
        .stall_count_o  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    // Monitor: compares whenever the stimulus announces that the DUT outputs
    // for a vector are settled.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sample_without_expectation: queue empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (stall !== e.st || ex_bubble !== e.bub || pc_write !== !e.st ||
                    ifid_write !== !e.st || fwd_a !== e.fa || fwd_b !== e.fb ||
                    stall_count !== e.cnt) begin
                    errors++;
                    $display("FAIL %s: got stall=%b bub=%b pcw=%b ifid=%b fa=%b fb=%b cnt=%0d, want stall=%b bub=%b pcw=%b ifid=%b fa=%b fb=%b cnt=%0d",
                             e.name, stall, ex_bubble, pc_write, ifid_write, fwd_a, fwd_b, stall_count,
                             e.st, e.bub, !e.st, !e.st, e.fa, e.fb, e.cnt);
                end
            end
        end
    end

    task automatic expect_now(input logic st, input logic bub, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [3:0] cnt, input string nm);
        exp_t e;
        e.st = st; e.bub = bub; e.fa = fa; e.fb = fb; e.cnt = cnt; e.name = nm;
        exp_q.push_back(e);
        -> chk_ev;
    endtask

    // One pipeline cycle: drive ID after the edge, check before the next one.
    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic [4:0] dst, input logic rw,
                        input logic mr, input logic fl,
                        input logic st, input logic bub, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] cnt, input string nm);
        @(posedge clk);
        #1;
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = dst; id_reg_write = rw; id_mem_read = mr; flush = fl;
        @(negedge clk);
        expect_now(st, bub, fa, fb, cnt, nm);
    endtask

    task automatic idle(input logic [1:0] fa, input logic [1:0] fb,
                        input logic [3:0] cnt, input string nm);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, cnt, nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_dest = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reset pulse between edges while a stall is showing.
    task automatic mid_reset(input string nm);
        #1 rst = 1'b1;
        #1 expect_now(0, 0, 2'b00, 2'b00, 4'd0, nm);
        #1 rst = 1'b0;
    endtask

    function automatic logic [3:0] sat15(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    initial begin
        // Reset state, with flush high to show ex_bubble is held low in reset.
        rst = 1'b1;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_dest = 0; id_reg_write = 0; id_mem_read = 0; flush = 1;
        #3 expect_now(0, 0, 2'b00, 2'b00, 4'd0, "reset_state");

        // Load-use, then reset in the middle of a stall.
        do_reset();
        //    v rs rt urt dst rw mr fl   st bub fa     fb     cnt
        step(1, 1, 0, 0,  2,  1, 1, 0,   0, 0, 2'b00, 2'b00, 0, "lu_lw");
`ifdef HAZARD_FORWARD_EN
        step(1, 2, 3, 1,  4,  1, 0, 0,   1, 1, 2'b00, 2'b00, 0, "lu_use_stall");
        step(1, 2, 3, 1,  4,  1, 0, 0,   0, 0, 2'b00, 2'b00, 1, "lu_use_go");
        step(1, 4, 0, 0,  9,  1, 1, 0,   0, 0, 2'b10, 2'b00, 1, "lu_ex_fwd_mem");
        step(1, 9, 0, 0, 10,  1, 0, 0,   1, 1, 2'b01, 2'b00, 1, "rm_stall");
`else
        step(1, 2, 3, 1,  4,  1, 0, 0,   1, 1, 2'b00, 2'b00, 0, "lu_use_stall1");
        step(1, 2, 3, 1,  4,  1, 0, 0,   1, 1, 2'b00, 2'b00, 1, "lu_use_stall2");
        step(1, 2, 3, 1,  4,  1, 0, 0,   0, 0, 2'b00, 2'b00, 2, "lu_use_go");
        step(1, 0, 0, 0,  9,  1, 1, 0,   0, 0, 2'b00, 2'b00, 2, "rm_lw");
        step(1, 9, 0, 0, 10,  1, 0, 0,   1, 1, 2'b00, 2'b00, 2, "rm_stall");
`endif
        mid_reset("rm_after_rst");

        // ALU RAW, producer immediately ahead.
        do_reset();
        step(1, 1, 2, 1,  3,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "alu_add");
`ifdef HAZARD_FORWARD_EN
        step(1, 4, 3, 1,  5,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "alu_sub");
        idle(2'b00, 2'b01, 0, "alu_sub_ex");
`else
        step(1, 4, 3, 1,  5,  1, 0, 0,   1, 1, 2'b00, 2'b00, 0, "alu_sub_stall1");
        step(1, 4, 3, 1,  5,  1, 0, 0,   1, 1, 2'b00, 2'b00, 1, "alu_sub_stall2");
        step(1, 4, 3, 1,  5,  1, 0, 0,   0, 0, 2'b00, 2'b00, 2, "alu_sub_go");
        idle(2'b00, 2'b00, 2, "alu_sub_ex");
`endif

        // ALU RAW with one instruction between producer and consumer.
        do_reset();
        step(1, 1, 0, 0,  6,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "d2_add");
        step(1, 0, 0, 0,  7,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "d2_mid");
`ifdef HAZARD_FORWARD_EN
        step(1, 6, 0, 0,  8,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "d2_use");
        idle(2'b10, 2'b00, 0, "d2_use_ex");
`else
        step(1, 6, 0, 0,  8,  1, 0, 0,   1, 1, 2'b00, 2'b00, 0, "d2_use_stall");
        step(1, 6, 0, 0,  8,  1, 0, 0,   0, 0, 2'b00, 2'b00, 1, "d2_use_go");
        idle(2'b00, 2'b00, 1, "d2_use_ex");
`endif

        // $zero destination never creates a hazard or a forward.
        do_reset();
        step(1, 1, 0, 0,  0,  1, 1, 0,   0, 0, 2'b00, 2'b00, 0, "zero_prod");
        step(1, 0, 0, 1, 11,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "zero_use");
        idle(2'b00, 2'b00, 0, "zero_use_ex");

        // Flush beats a load-use stall; the flushed load never reaches EX.
        do_reset();
        step(1, 1, 0, 0,  2,  1, 1, 0,   0, 0, 2'b00, 2'b00, 0, "fl_lw");
        step(1, 2, 0, 0,  8,  1, 1, 1,   0, 1, 2'b00, 2'b00, 0, "fl_flushed");
        step(1, 8, 0, 0, 12,  1, 0, 0,   0, 0, 2'b00, 2'b00, 0, "fl_ex_empty");

        // Counter saturation: 20 stall cycles into a 4-bit counter.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, sat15(i - 1),
                 $sformatf("sat_lw_%0d", i));
            step(1, 2, 0, 0, 3, 1, 0, 0, 1, 1, 2'b00, 2'b00, sat15(i - 1),
                 $sformatf("sat_use_%0d", i));
        end
        idle(2'b00, 2'b00, 4'd15, "sat_final");
        idle(2'b00, 2'b00, 4'd15, "sat_hold");

        #20;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS pipeline. It sits beside the ID stage and its register file, and keeps a shadow record of the destination, `regWrite` and `memRead` state of the instructions in EX, MEM and WB. From that record it detects read-after-write hazards, stalls the PC and IF/ID registers, and injects bubbles into ID/EX. When forwarding is compiled in, it also produces registered ALU operand-forward selects.

## Interface
- `CNT_W`, 16: width of the saturating stall counter.
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `idValid` input 1: the ID stage holds a real instruction.
- `idRs` input 5: rs field of the ID instruction.
- `idRt` input 5: rt field of the ID instruction.
- `idUsesRt` input 1: the ID instruction reads rt as a source (R-type, beq, sw).
- `idDest` input 5: destination register, already muxed by `regDst`.
- `idRegWrite` input 1: the ID instruction writes the register file.
- `idMemRead` input 1: the ID instruction is a load.
- `flush` input 1: a taken branch or jump kills the ID instruction this cycle.
- `stall` output 1: a hazard is detected (combinational).
- `pcWrite` output 1: equals `!stall`.
- `ifidWrite` output 1: equals `!stall`.
- `exBubble` output 1: equals `stall | flush`; zeroes the ID/EX control fields.
- `fwdA` output 2: operand-A forward select for the instruction currently in EX (registered). 00 = register file, 01 = EX/MEM, 10 = MEM/WB.
- `fwdB` output 2: same as `fwdA`, for operand B.
- `stallCount` output `CNT_W`: saturating count of stall cycles.

## Operation
- **Shadow pipeline.** Three entries, `sEX`, `sMEM`, `sWB`. Each entry holds {valid, dest, regWrite, memRead}.
- **Shadow advance.** Every rising edge: `sWB` takes `sMEM`, and `sMEM` takes `sEX`. `sEX` takes the ID fields when `idValid & !exBubble`; otherwise it becomes an invalid bubble.
- **Match definition.** An entry matches the ID instruction when all of the following hold:
  - the entry is valid and has `regWrite = 1`;
  - its dest is not 0;
  - dest equals `idRs`, or (`idUsesRt` and dest equals `idRt`).
- **No WB hazard.** The register file writes on the rising edge and reads on the falling edge, so `sWB` never causes a hazard.
- **Stall rule.** `stall` is asserted when `idValid & !flush` and the hazard condition holds. The hazard condition depends on the configuration (see Configuration).
- **Flush priority.** `flush` overrides `stall`. The ID instruction is dropped, `stall = 0` and `exBubble = 1`.
- **Forward selects.** These are computed in ID and registered into `fwdA`/`fwdB` on the edge where the instruction enters EX.
  - Operand A, checked against `idRs`: if `sEX` matches, select 01. Else if `sMEM` matches, select 10. Else select 00.
  - Operand B uses `idRt` and applies only if `idUsesRt`.
  - On a bubble, both selects register 00.
- **Stall counter.** `stallCount` increments on each edge where `stall = 1`. It saturates at all ones and never wraps.

## Timing
- `stall`, `pcWrite`, `ifidWrite` and `exBubble` are combinational from the current inputs and the shadow state, so they are valid in the same cycle.
- Load-use with forwarding: exactly 1 stall cycle.
- RAW without forwarding: 2 stall cycles if the producer is immediately ahead; 1 stall cycle if one instruction separates producer and consumer.
- `fwdA`/`fwdB` have 1-cycle latency; they are valid during the consumer's EX cycle.
- **Reset.** On `rst` assertion, asynchronously:
  - all shadow entries become invalid;
  - `fwdA = fwdB = 00` and `stallCount = 0`;
  - `stall = 0` and `exBubble = 0`, so `pcWrite = ifidWrite = 1`;
  - a stall in progress is abandoned immediately.
- Reset release takes effect on the next rising edge.
- `flush` and `stall` conditions in the same cycle: treated as a flush, with no count increment.
- Hazard terms ignore `idValid = 0` (no stall, no count).

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - stall only on load-use, i.e. `sEX` valid, `memRead = 1`, and `sEX` matches;
  - `fwdA`/`fwdB` are generated as described in Operation.
- `HAZARD_FORWARD_EN` undefined:
  - stall whenever `sEX` or `sMEM` matches;
  - `fwdA`/`fwdB` are tied to 00 and the forward logic is not synthesised.

## Test plan
1. **Reset mid-stall.** Load `sEX` with dest=2, memRead=1; drive ID rs=2 so `stall=1`; pulse `rst` between edges. Required: `stall=0`, `pcWrite=1`, `stallCount=0`, `fwdA=00` immediately.
2. **Load-use (forwarding on).** lw dest=2, then add rs=2 rt=3 `idUsesRt=1`. Required: `stall=1` and `exBubble=1` for 1 cycle. The next cycle has `stall=0`; after add enters EX, `fwdA=10` and `fwdB=00`; `stallCount=1`.
3. **ALU RAW (forwarding on).** add dest=3, then sub rs=4 rt=3. Required: no stall; in sub's EX cycle `fwdA=00` and `fwdB=01`.
4. **ALU RAW (forwarding off).** Same sequence as scenario 3. Required: `stall=1` for 2 consecutive cycles, then 0; `stallCount=2`; `fwdA=fwdB=00` throughout.
5. **$zero and flush.** Producer dest=0 followed by a consumer with rs=0: no stall. Separately, a load-use pair with `flush=1` on the consumer cycle: `stall=0`, `exBubble=1`, and `sEX` is invalid afterwards.
6. **Counter saturation.** With `CNT_W=4`, hold a hazard for 20 cycles. Required: `stallCount` reaches 15 and stays at 15.
